sig_playback: RTL and testbench

- Record-then-replay buffer for the signal path.
- Captures a block of mic samples into a dual-port RAM, then streams them back out over a valid/ready interface, once or looped.
- It is the reader-driven counterpart to the delay line: playback is sequenced by the consumer's ready rather than by write-address offset.
- Sits between the mic sample source and the DAC/plot sink.

---
 rtl/sig_pkg.sv | 12 +
 rtl/ram2ports.sv | 24 ++
 rtl/sig_playback.sv | 131 +++++++++++++
 tb/tb_sig_playback.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sig_pkg.sv
// rtl/sig_pkg.sv - shared state encoding and default widths for the record/replay buffer
package sig_pkg;
    localparam int DEF_A_WIDTH = 9;
    localparam int DEF_D_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        RECORD,
        STORED,
        PLAY
    } state_t;
endpackage

// File: rtl/ram2ports.sv
// rtl/ram2ports.sv - simple dual-port RAM, synchronous write and synchronous read
module ram2ports #(
    parameter int A_WIDTH = 8,
    parameter int D_WIDTH = 8
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [A_WIDTH-1:0] wr_addr,
    input  logic [D_WIDTH-1:0] wr_data,
    input  logic               rd_en,
    input  logic [A_WIDTH-1:0] rd_addr,
    output logic [D_WIDTH-1:0] rd_data
);
    logic [D_WIDTH-1:0] mem [0:(2**A_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/sig_playback.sv
// rtl/sig_playback.sv - record a block of samples, then replay it over valid/ready, once or looped
module sig_playback
    import sig_pkg::*;
#(
    parameter int A_WIDTH = DEF_A_WIDTH,
    parameter int D_WIDTH = DEF_D_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_rec,
    input  logic [A_WIDTH-1:0] rec_len,
    input  logic               sample_en,
    input  logic [D_WIDTH-1:0] sample_in,
    input  logic               start_play,
    input  logic               loop,
    input  logic               stop,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [D_WIDTH-1:0] out_data,
    output logic               busy,
    output logic               rec_done
);
    state_t             state, state_nxt;
    logic [A_WIDTH-1:0] wr_ptr, rd_ptr, len_q;
    logic               rd_more, rd_pend, skid_valid;
    logic [D_WIDTH-1:0] skid_data, rd_data;
    logic               wr_en, rd_en, pop, play_end;
    logic [1:0]         held;

    assign pop  = out_valid & out_ready;
    // samples sitting in the output buffer once this edge has absorbed any returning read
    assign held = 2'(out_valid) + 2'(skid_valid) + 2'(rd_pend) - 2'(pop);

    assign busy     = (state == RECORD) || (state == PLAY);
    assign rec_done = (state == STORED) || (state == PLAY);

    ram2ports #(
        .A_WIDTH(A_WIDTH),
        .D_WIDTH(D_WIDTH)
    ) u_ram (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_addr(wr_ptr),
        .wr_data(sample_in),
        .rd_en  (rd_en),
        .rd_addr(rd_ptr),
        .rd_data(rd_data)
    );

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        play_end  = 1'b0;
        case (state)
            IDLE: begin
                if (start_rec) state_nxt = RECORD;
            end
            RECORD: begin
                wr_en = sample_en;
                if (sample_en && (wr_ptr == len_q)) state_nxt = STORED;
            end
            STORED: begin
                if (start_rec)       state_nxt = RECORD;
                else if (start_play) state_nxt = PLAY;
            end
            PLAY: begin
                play_end = !rd_more && pop && !skid_valid && !rd_pend;
                rd_en    = !stop && rd_more && (held <= 2'd1);
                if (stop || play_end) state_nxt = STORED;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            len_q      <= '0;
            rd_more    <= 1'b0;
            rd_pend    <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else begin
            state   <= state_nxt;
            rd_pend <= rd_en;

            if ((state_nxt == RECORD) && (state != RECORD)) begin
                len_q  <= rec_len;
                wr_ptr <= '0;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + A_WIDTH'(1);
            end

            if ((state_nxt == PLAY) && (state != PLAY)) begin
                rd_ptr  <= '0;
                rd_more <= 1'b1;
            end else if (rd_en) begin
                // loop is only looked at here, when the last address is issued
                if (rd_ptr == len_q) begin
                    rd_ptr  <= '0;
                    rd_more <= loop;
                end else begin
                    rd_ptr <= rd_ptr + A_WIDTH'(1);
                end
            end

            if ((state != PLAY) || stop) begin
                out_valid  <= 1'b0;
                skid_valid <= 1'b0;
            end else if (!out_valid || out_ready) begin
                if (skid_valid) begin
                    out_valid  <= 1'b1;
                    out_data   <= skid_data;
                    skid_valid <= rd_pend;
                    skid_data  <= rd_data;
                end else begin
                    out_valid <= rd_pend;
                    if (rd_pend) out_data <= rd_data;
                end
            end else if (rd_pend) begin
                skid_valid <= 1'b1;
                skid_data  <= rd_data;
            end
        end
    end
endmodule

// File: tb/tb_sig_playback.sv
// tb/tb_sig_playback.sv - randomized self-checking bench for sig_playback against a sample-order model
module tb_sig_playback;
    localparam int AW = 9;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_rec, sample_en, start_play, loop, stop, out_ready;
    logic [AW-1:0] rec_len;
    logic [DW-1:0] sample_in;
    logic          out_valid, busy, rec_done;
    logic [DW-1:0] out_data;

    always #5 clk = ~clk;

    sig_playback #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_rec (start_rec),
        .rec_len   (rec_len),
        .sample_en (sample_en),
        .sample_in (sample_in),
        .start_play(start_play),
        .loop      (loop),
        .stop      (stop),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .rec_done  (rec_done)
    );

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] model_mem [0:511];
    int            model_n = 1;
    int            exp_idx = 0;
    int            n_xfer = 0;
    bit            mon_en = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data = '0;
    logic [DW-1:0] got[$];
    logic [DW-1:0] exp_q[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Replay model: transfers walk the stored block 0..N-1 and wrap; held data must not move
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall) begin
                chk("stall_hold_valid", out_valid, 1);
                chk("stall_hold_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                chk("xfer_data", out_data, model_mem[exp_idx]);
                got.push_back(out_data);
                exp_idx = (exp_idx + 1 == model_n) ? 0 : exp_idx + 1;
                n_xfer++;
            end
            prev_stall = out_valid && !out_ready && !stop;
            prev_data  = out_data;
        end else begin
            prev_stall = 0;
        end
    end

    function automatic logic rdy(input int mode, input int c);
        logic [5:0] pat;
        pat = 6'b101001;
        case (mode)
            0:       return 1'b1;
            1:       return ($urandom_range(0, 2) != 0);
            default: return pat[c % 6];
        endcase
    endfunction

    task automatic record(input int len, input bit gaps, input bit also_play);
        start_rec  = 1;
        start_play = also_play;
        rec_len    = AW'(len);
        tick();
        start_rec  = 0;
        start_play = 0;
        rec_len    = '0;
        model_n    = len + 1;
        chk("rec_busy", busy, 1);
        chk("rec_done_low", rec_done, 0);
        chk("rec_no_valid", out_valid, 0);
        for (int i = 0; i <= len; i++) begin
            while (gaps && $urandom_range(0, 3) == 0) begin
                sample_en  = 0;
                sample_in  = DW'($urandom);
                start_play = 1'($urandom_range(0, 1));
                tick();
                start_play = 0;
            end
            sample_en = 1;
            sample_in = model_mem[i];
            tick();
            sample_en = 0;
            if (i < len) chk("rec_busy_mid", busy, 1);
        end
        chk("rec_done_set", rec_done, 1);
        chk("rec_idle", busy, 0);
    endtask

    // loop_until: loop is driven 1 for the edges k+c with c < loop_until (edge k takes start_play)
    task automatic play(input int rmode, input int loop_until, input int stop_at, input int exp_count);
        bit done;
        exp_idx = 0;
        n_xfer  = 0;
        got.delete();
        mon_en     = 1;
        start_play = 1;
        loop       = (loop_until > 0);
        out_ready  = rdy(rmode, 0);
        tick();
        start_play = 0;
        chk("lat_edge_k", out_valid, 0);
        chk("busy_play", busy, 1);
        done = 0;
        for (int c = 1; c <= 3000 && !done; c++) begin
            loop      = (c < loop_until);
            out_ready = rdy(rmode, c);
            stop      = (c == stop_at);
            tick();
            stop = 0;
            if (c == 1) chk("lat_edge_k1", out_valid, 0);
            if (c == 2) begin
                chk("lat_edge_k2", out_valid, 1);
                chk("first_data", out_data, model_mem[0]);
            end
            if (c == stop_at) begin
                chk("stop_valid", out_valid, 0);
                chk("stop_busy", busy, 0);
            end
            if (!busy) begin
                done = 1;
                if (rmode == 0 && stop_at == 0) chk("end_edge_no_bubble", c, exp_count + 2);
            end
        end
        chk("play_finished", busy, 0);
        chk("valid_after_play", out_valid, 0);
        chk("stored_after_play", rec_done, 1);
        if (exp_count >= 0) chk("xfer_count", n_xfer, exp_count);
        mon_en    = 0;
        loop      = 0;
        out_ready = 0;
        tick();
    endtask

    task automatic lit_check(input string name);
        chk({name, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) chk(name, got[i], exp_q[i]);
    endtask

    function automatic int loop_count(input int n, input int l);
        return (l > 0) ? n * (1 + (l - 1) / n) : n;
    endfunction

    initial begin
        int len, n, mode, l;
        rst = 0; start_rec = 0; rec_len = '0; sample_en = 0; sample_in = '0;
        start_play = 0; loop = 0; stop = 0; out_ready = 0;
        repeat (2) tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rec_done", rec_done, 0);
        rst = 1;
        tick();
        start_play = 1;
        tick();
        start_play = 0;
        chk("idle_play_ignored", busy, 0);
        repeat (2) tick();
        chk("idle_no_valid", out_valid, 0);
        chk("idle_no_rec_done", rec_done, 0);

        model_mem[0] = 8'h10; model_mem[1] = 8'h20; model_mem[2] = 8'h30; model_mem[3] = 8'h40;
        record(3, 0, 0);
        exp_q = {8'h10, 8'h20, 8'h30, 8'h40};
        play(0, 0, 0, 4);
        lit_check("seq_basic");
        play(2, 0, 0, 4);
        lit_check("seq_backpressure");
        play(1, 0, 0, 4);
        lit_check("seq_random_ready");

        model_mem[0] = 8'hAA; model_mem[1] = 8'h55;
        record(1, 0, 0);
        exp_q = {8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55};
        play(0, 100, 8, 6);
        lit_check("seq_loop_stop");
        exp_q = {8'hAA, 8'h55, 8'hAA, 8'h55};
        play(0, 4, 0, loop_count(2, 4));
        lit_check("seq_loop_drop");

        for (int i = 0; i < 5; i++) model_mem[i] = DW'($urandom);
        record(4, 1, 1);
        play(1, 0, 0, 5);

        for (int t = 0; t < 10; t++) begin
            len = $urandom_range(0, 40);
            n   = len + 1;
            for (int i = 0; i < n; i++) model_mem[i] = DW'($urandom);
            record(len, 1, 0);
            mode = $urandom_range(0, 2);
            if (mode == 0) begin
                l = $urandom_range(0, 3 * n + 2);
                play(0, l, 0, loop_count(n, l));
            end else begin
                play(mode, 0, 0, n);
            end
            if (t % 3 == 0) play(1, 5000, 3 + $urandom_range(0, 60), -1);
        end

        start_play = 1; out_ready = 1;
        tick();
        start_play = 0;
        repeat (3) tick();
        #2 rst = 0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_rec_done", rec_done, 0);
        tick();
        rst = 1;
        start_play = 1;
        tick();
        start_play = 0;
        chk("post_rst_play_ignored", busy, 0);
        repeat (2) tick();
        chk("post_rst_no_valid", out_valid, 0);
        out_ready = 0;

        model_mem[0] = 8'h5C;
        record(0, 0, 0);
        exp_q = {8'h5C};
        play(0, 0, 0, 1);
        lit_check("seq_single");
        play(0, 7, 0, loop_count(1, 7));

        for (int i = 0; i < 512; i++) model_mem[i] = DW'($urandom);
        record(511, 0, 0);
        play(0, 0, 0, 512);
        chk("full_len", got.size(), 512);
        if (got.size() == 512) chk("full_last", got[511], model_mem[511]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
